// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths and FSM state for the BCD to binary converter.
package bcd_pkg;
  localparam int NUM_DIGITS = 3;
  localparam int DIGIT_W = 4;
  localparam int BIN_W = 10;
  localparam int ITER = 10;
  localparam int SR_W = NUM_DIGITS * DIGIT_W + BIN_W;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: reverse double-dabble digit correction, subtract 3 from digits of 8 or more.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_d,
  output logic [DIGIT_W-1:0] o_d
);
  assign o_d = (i_d >= 4'd8) ? i_d - 4'd3 : i_d;
endmodule

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: 3-digit BCD to 10-bit binary, one bit per clock via reverse double-dabble.
// Optional invalid-digit check enabled by defining BCD_TO_BINARY_CHECK_EN.
module bcd_to_binary
  import bcd_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   bcd2,
  input  logic [3:0]   bcd1,
  input  logic [3:0]   bcd0,
  output logic [9:0]   bin,
  output logic         busy,
  output logic         done,
  output logic         err
);
  state_t          r_state;
  logic [SR_W-1:0] r_sr;
  logic [3:0]      r_cnt;
  logic [SR_W-1:0] w_sh;
  logic [SR_W-1:0] w_nx;
  assign w_sh = r_sr >> 1;
  assign w_nx[BIN_W-1:0] = w_sh[BIN_W-1:0];
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_d(w_sh[BIN_W+DIGIT_W*i +: DIGIT_W]),
      .o_d(w_nx[BIN_W+DIGIT_W*i +: DIGIT_W])
    );
  end
`ifdef BCD_TO_BINARY_CHECK_EN
  logic r_inv;
  logic w_bad;
  assign w_bad = (bcd2 > 4'd9) | (bcd1 > 4'd9) | (bcd0 > 4'd9);
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr <= '0;
      r_cnt <= '0;
      bin <= '0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef BCD_TO_BINARY_CHECK_EN
      r_inv <= 1'b0;
      err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_state <= SHIFT;
          r_sr <= {bcd2, bcd1, bcd0, {BIN_W{1'b0}}};
          r_cnt <= '0;
          busy <= 1'b1;
`ifdef BCD_TO_BINARY_CHECK_EN
          r_inv <= w_bad;
`endif
        end
      end else begin
        r_sr <= w_nx;
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'(ITER - 1)) begin
          r_state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
`ifdef BCD_TO_BINARY_CHECK_EN
          bin <= r_inv ? '0 : w_nx[BIN_W-1:0];
          err <= r_inv;
`else
          bin <= w_nx[BIN_W-1:0];
`endif
        end
      end
    end
  end
endmodule
